// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU execution sequencer: opcodes, alu_ctl bit
// positions, FSM state encoding and the opcode-to-strobe mapping.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd9;
  localparam logic [4:0] OP_ANDI = 5'd10;
  localparam logic [4:0] OP_ORI  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd12;
  localparam logic [4:0] OP_DIV  = 5'd13;
  localparam logic [4:0] OP_NEG  = 5'd14;
  localparam logic [4:0] OP_NOT  = 5'd15;

  localparam int CTL_W    = 13;
  localparam int CTL_ADD  = 0;
  localparam int CTL_SUB  = 1;
  localparam int CTL_AND  = 2;
  localparam int CTL_OR   = 3;
  localparam int CTL_SHR  = 4;
  localparam int CTL_SHRA = 5;
  localparam int CTL_SHL  = 6;
  localparam int CTL_ROR  = 7;
  localparam int CTL_ROL  = 8;
  localparam int CTL_NEG  = 9;
  localparam int CTL_NOT  = 10;
  localparam int CTL_MUL  = 11;
  localparam int CTL_DIV  = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_Y = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB_LO  = 3'd3,
    ST_WB_HI  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Immediate forms reuse the strobe of their register counterpart.
  function automatic logic [CTL_W-1:0] op_to_ctl(input logic [4:0] op);
    logic [CTL_W-1:0] ctl;
    ctl = '0;
    case (op)
      OP_ADD, OP_ADDI: ctl[CTL_ADD]  = 1'b1;
      OP_SUB:          ctl[CTL_SUB]  = 1'b1;
      OP_AND, OP_ANDI: ctl[CTL_AND]  = 1'b1;
      OP_OR,  OP_ORI:  ctl[CTL_OR]   = 1'b1;
      OP_SHR:          ctl[CTL_SHR]  = 1'b1;
      OP_SHRA:         ctl[CTL_SHRA] = 1'b1;
      OP_SHL:          ctl[CTL_SHL]  = 1'b1;
      OP_ROR:          ctl[CTL_ROR]  = 1'b1;
      OP_ROL:          ctl[CTL_ROL]  = 1'b1;
      OP_NEG:          ctl[CTL_NEG]  = 1'b1;
      OP_NOT:          ctl[CTL_NOT]  = 1'b1;
      OP_MUL:          ctl[CTL_MUL]  = 1'b1;
      OP_DIV:          ctl[CTL_DIV]  = 1'b1;
      default:         ctl = '0;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_exec_sequencer_decode.sv
// Combinational opcode classifier: ALU strobe vector plus the operand-routing
// and writeback attributes the sequencer needs.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0]       op,
  output logic [CTL_W-1:0] alu_ctl,
  output logic             is_imm,
  output logic             is_unary,
  output logic             is_muldiv,
  output logic             is_illegal
);

  always_comb begin
    alu_ctl    = op_to_ctl(op);
    is_illegal = op[4];
    is_imm     = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    is_unary   = (op == OP_NEG) || (op == OP_NOT);
    is_muldiv  = (op == OP_MUL) || (op == OP_DIV);
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Control sequencer for one ALU-class instruction: Y load, execute with Z
// capture, Z writeback to a register or HI/LO. Outputs are registered.
module alu_exec_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MULDIV_EXEC_CYCLES = 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [4:0]       opcode,
  output logic [CTL_W-1:0] alu_ctl,
  output logic             Rout_a,
  output logic             Rout_b,
  output logic             Cout,
  output logic             Yin,
  output logic             Zin,
  output logic             ZLowout,
  output logic             ZHighout,
  output logic             Rin,
  output logic             LOin,
  output logic             HIin,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_EXEC_CYCLES - 1);

  state_t           state;
  state_t           nxt_state;
  logic [4:0]       op_q;
  logic [4:0]       nxt_op;
  logic [4:0]       dec_op;
  logic [3:0]       cnt;
  logic [3:0]       nxt_cnt;
  logic             reject;
  logic [CTL_W-1:0] dec_ctl;
  logic             dec_imm;
  logic             dec_unary;
  logic             dec_muldiv;
  logic             dec_illegal;

  // In IDLE the live opcode is classified so an accepted request is decoded
  // for the very state it enters; otherwise the latched opcode rules.
  assign dec_op = (state == ST_IDLE) ? opcode : op_q;

  alu_op_decode u_decode (
    .op         (dec_op),
    .alu_ctl    (dec_ctl),
    .is_imm     (dec_imm),
    .is_unary   (dec_unary),
    .is_muldiv  (dec_muldiv),
    .is_illegal (dec_illegal)
  );

  always_comb begin
    nxt_state = state;
    nxt_op    = op_q;
    nxt_cnt   = cnt;
    reject    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (dec_illegal) begin
            reject = 1'b1;
          end else begin
            nxt_state = ST_LOAD_Y;
            nxt_op    = opcode;
          end
        end
      end
      ST_LOAD_Y: begin
        nxt_state = ST_EXEC;
        nxt_cnt   = dec_muldiv ? MD_LOAD : 4'd0;
      end
      ST_EXEC: begin
        if (cnt == 4'd0) nxt_state = ST_WB_LO;
        else             nxt_cnt   = cnt - 4'd1;
      end
      ST_WB_LO: nxt_state = dec_muldiv ? ST_WB_HI : ST_DONE;
      ST_WB_HI: nxt_state = ST_DONE;
      ST_DONE:  nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered, so each register holds
  // exactly the Moore value of the current state.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      cnt      <= '0;
      alu_ctl  <= '0;
      Rout_a   <= 1'b0;
      Rout_b   <= 1'b0;
      Cout     <= 1'b0;
      Yin      <= 1'b0;
      Zin      <= 1'b0;
      ZLowout  <= 1'b0;
      ZHighout <= 1'b0;
      Rin      <= 1'b0;
      LOin     <= 1'b0;
      HIin     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= nxt_state;
      op_q     <= nxt_op;
      cnt      <= nxt_cnt;
      illegal  <= reject;
      busy     <= (nxt_state != ST_IDLE);
      alu_ctl  <= '0;
      Rout_a   <= 1'b0;
      Rout_b   <= 1'b0;
      Cout     <= 1'b0;
      Yin      <= 1'b0;
      Zin      <= 1'b0;
      ZLowout  <= 1'b0;
      ZHighout <= 1'b0;
      Rin      <= 1'b0;
      LOin     <= 1'b0;
      HIin     <= 1'b0;
      done     <= 1'b0;
      case (nxt_state)
        ST_LOAD_Y: begin
          Yin    <= 1'b1;
          Rout_a <= !dec_unary;
          Rout_b <= dec_unary;
        end
        ST_EXEC: begin
          alu_ctl <= dec_ctl;
          Cout    <= dec_imm;
          Rout_b  <= !dec_imm && !dec_unary;
          Zin     <= (nxt_cnt == 4'd0);
        end
        ST_WB_LO: begin
          ZLowout <= 1'b1;
          Rin     <= !dec_muldiv;
          LOin    <= dec_muldiv;
        end
        ST_WB_HI: begin
          ZHighout <= 1'b1;
          HIin     <= 1'b1;
        end
        ST_DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Control-side counterpart of the datapath ALU: drives the ALU's one-hot operation strobes and consumes its 64-bit result through the Z register.
- Accepts one decoded ALU-class instruction per start pulse.
- Sequences Y load, ALU execute with Z capture, and Z writeback to the destination register or to HI/LO.
- Sits between instruction decode and the datapath bus/register enables.

Parameters:
- MULDIV_EXEC_CYCLES, 1, number of EXEC cycles for MUL/DIV (legal 1..16); all other ops use 1 EXEC cycle.

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- opcode  in  5  ALU opcode, captured on accepted start
- alu_ctl  out  13  one-hot ALU strobe, bit order ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEGATE,NOT,MUL,DIV (bit0..bit12)
- Rout_a  out  1  drive source register A onto bus
- Rout_b  out  1  drive source register B onto bus
- Cout  out  1  drive sign-extended immediate onto bus
- Yin  out  1  load Y from bus
- Zin  out  1  load Z (64-bit) from ALU C
- ZLowout  out  1  drive Z[31:0] onto bus
- ZHighout  out  1  drive Z[63:32] onto bus
- Rin  out  1  write destination register from bus
- LOin  out  1  load LO from bus
- HIin  out  1  load HI from bus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- illegal  out  1  one-cycle pulse when an undefined opcode is accepted

Behaviour:
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8, ADDI 9, ANDI 10, ORI 11, MUL 12, DIV 13, NEG 14, NOT 15. Opcodes 16-31 are illegal.
- FSM states: IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE. All outputs are Moore outputs decoded from state and the latched opcode, so outputs are glitch-free.
- IDLE:
  - start=1 with a legal opcode: latch opcode, go to LOAD_Y.
  - start=1 with an illegal opcode: pulse illegal the next cycle, stay IDLE, assert no strobes.
- LOAD_Y: Yin=1. Source is Rout_b for NEG/NOT, Rout_a for all other ops.
- EXEC:
  - alu_ctl carries the op's bit for every EXEC cycle.
  - Bus driver: Rout_b for register ops and MUL/DIV; Cout for ADDI (ADD bit), ANDI (AND bit), ORI (OR bit); none for NEG/NOT.
  - MUL/DIV hold EXEC for MULDIV_EXEC_CYCLES cycles via a 4-bit down-counter. Zin is asserted only in the final EXEC cycle.
  - Next state: WB_LO.
- WB_LO: ZLowout=1. Rin=1 for non-MUL/DIV ops; LOin=1 for MUL/DIV. Next state: WB_HI for MUL/DIV, otherwise DONE.
- WB_HI: ZHighout=1, HIin=1. Next state: DONE.
- DONE: done=1, busy=1. Next state: IDLE.
- Latency from start to done, counting the start cycle as 0: done in cycle 4 for single-EXEC ops; cycle 4+MULDIV_EXEC_CYCLES for MUL/DIV.
- Invariants:
  - At most one of Rout_a, Rout_b, Cout, ZLowout, ZHighout is high in any cycle.
  - alu_ctl is zero or exactly one-hot, and is nonzero only in EXEC.
  - At most one of Rin, LOin, HIin, Yin, Zin is high in any cycle.
- start while busy is ignored and not queued. An opcode change while busy has no effect.
- start asserted in the DONE cycle is ignored; a new request is accepted at the earliest in the following IDLE cycle.
- Reset (clear_n=0, any time including mid-operation):
  - state returns to IDLE immediately (asynchronously);
  - all outputs go to 0, and the latched opcode and counter go to 0;
  - a partial writeback is simply abandoned.
- Each MUL/DIV counter reload starts from MULDIV_EXEC_CYCLES-1; no wrap beyond the count.

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode constants;
  - alu_ctl bit-index constants;
  - state encoding (3-bit enum);
  - a function mapping opcode to the one-hot alu_ctl value.
- One natural sub-module, alu_op_decode: a combinational mapping from opcode to alu_ctl vector, is_imm, is_unary, is_muldiv and is_illegal. The FSM lives in the top block.

Test Plan:
- ADD (op 0) start at cycle 0: cycle1 Rout_a+Yin; cycle2 alu_ctl=13'h0001+Rout_b+Zin; cycle3 ZLowout+Rin; cycle4 done; busy high cycles 1-4.
- ORI (op 11): cycle2 alu_ctl=13'h0008 with Cout=1 and Rout_b=0; writeback via Rin; done at cycle 4.
- MUL (op 12) with MULDIV_EXEC_CYCLES=3:
  - alu_ctl=13'h0800 held in cycles 2-4, Zin only in cycle 4;
  - cycle5 ZLowout+LOin; cycle6 ZHighout+HIin; cycle7 done.
- NEG (op 14): cycle1 Rout_b+Yin; cycle2 alu_ctl=13'h0200, Zin=1, no bus driver; done at cycle 4.
- Opcode 20 with start: illegal pulses exactly one cycle, busy stays 0, all strobes stay 0. A start during busy for a DIV is ignored and produces exactly one done.
- clear_n low during WB_HI of DIV: all outputs 0 in the same cycle, state IDLE. After release, ADD completes normally with done 4 cycles after start.
